// File: rtl/heart_hit_manager_pkg.sv
// Shared definitions for the heart collision stage and the sprites that feed it:
// FSM encoding, screen end-of-frame coordinates and the fight game-state value.
package heart_hit_manager_pkg;

    localparam int COORD_W = 10;
    localparam int STATE_W = 4;
    localparam int HP_W    = 8;

    localparam int unsigned          H_LAST      = 639;
    localparam int unsigned          V_LAST      = 479;
    localparam logic [STATE_W-1:0]   FIGHT_STATE = 4'd1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ARMED  = 2'd1,
        ST_INVULN = 2'd2,
        ST_DEAD   = 2'd3
    } hit_fsm_e;

endpackage

// File: rtl/heart_hit_manager_frame_tick.sv
// End-of-frame decoder: purely combinational compare of the raster position
// against the last visible pixel, gated by an enable.
module heart_hit_manager_frame_tick #(
    parameter int unsigned H_LAST = heart_hit_manager_pkg::H_LAST,
    parameter int unsigned V_LAST = heart_hit_manager_pkg::V_LAST
) (
    input  logic       en,
    input  logic [9:0] x,
    input  logic [9:0] y,
    output logic       tick
);

    localparam logic [9:0] H_CMP = 10'(H_LAST);
    localparam logic [9:0] V_CMP = 10'(V_LAST);

    assign tick = en && (x == H_CMP) && (y == V_CMP);

endmodule

// File: rtl/heart_hit_manager.sv
// Heart/bullet collision manager: latches per-bullet overlaps across a frame and,
// at end of frame, applies damage, starts invincibility and pulses the hitting bullets.
module heart_hit_manager #(
    parameter int                NUM_BULLETS = 4,
    parameter int                HP_INIT     = 20,
    parameter int                DAMAGE      = 4,
    parameter int                IFRAMES     = 30,
    parameter int unsigned       H_LAST      = heart_hit_manager_pkg::H_LAST,
    parameter int unsigned       V_LAST      = heart_hit_manager_pkg::V_LAST,
    parameter logic [3:0]        FIGHT_STATE = heart_hit_manager_pkg::FIGHT_STATE
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [3:0]             state,
    input  logic [9:0]             x,
    input  logic [9:0]             y,
    input  logic                   heartSpriteOn,
    input  logic [NUM_BULLETS-1:0] bulletSpriteOn,
    output logic [NUM_BULLETS-1:0] collision,
    output logic [7:0]             hp,
    output logic                   hit,
    output logic                   invincible,
    output logic                   heartVisible,
    output logic                   gameOver
);

    import heart_hit_manager_pkg::*;

    localparam logic [HP_W-1:0] HP_RST = HP_W'(HP_INIT);
    localparam logic [HP_W-1:0] DMG    = HP_W'(DAMAGE);
    localparam logic [7:0]      IFR    = 8'(IFRAMES);

    // Saturating HP subtract: never wraps below zero.
    function automatic logic [HP_W-1:0] sat_sub(input logic [HP_W-1:0] a,
                                                input logic [HP_W-1:0] b);
        return (a > b) ? (a - b) : '0;
    endfunction

    hit_fsm_e               fsm_p1, fsm_d;
    logic [NUM_BULLETS-1:0] pend_p1, pend_d;
    logic [NUM_BULLETS-1:0] col_p1, col_d;
    logic [NUM_BULLETS-1:0] ov, eval_bits;
    logic [HP_W-1:0]        hp_p1, hp_d, hp_dmg;
    logic [7:0]             ifc_p1, ifc_d;
    logic                   hit_p1, hit_d;
    logic                   eof, fight;

    heart_hit_manager_frame_tick #(
        .H_LAST (H_LAST),
        .V_LAST (V_LAST)
    ) u_frame_tick (
        .en   (1'b1),
        .x    (x),
        .y    (y),
        .tick (eof)
    );

    assign fight     = (state == FIGHT_STATE);
    assign ov        = bulletSpriteOn & {NUM_BULLETS{heartSpriteOn}};
    // The last pixel's overlap is folded in here so it is not lost to the pending clear.
    assign eval_bits = pend_p1 | ov;
    assign hp_dmg    = sat_sub(hp_p1, DMG);

    // Stage p1: FSM and datapath registers
    always_ff @(posedge clk) begin
        if (reset) begin
            fsm_p1  <= ST_IDLE;
            pend_p1 <= '0;
            col_p1  <= '0;
            hp_p1   <= HP_RST;
            ifc_p1  <= '0;
            hit_p1  <= 1'b0;
        end else begin
            fsm_p1  <= fsm_d;
            pend_p1 <= pend_d;
            col_p1  <= col_d;
            hp_p1   <= hp_d;
            ifc_p1  <= ifc_d;
            hit_p1  <= hit_d;
        end
    end

    always_comb begin
        fsm_d  = fsm_p1;
        pend_d = pend_p1;
        col_d  = '0;
        hp_d   = hp_p1;
        ifc_d  = ifc_p1;
        hit_d  = 1'b0;
        unique case (fsm_p1)
            ST_IDLE: begin
                pend_d = '0;
                ifc_d  = '0;
                if (fight) fsm_d = ST_ARMED;
            end
            ST_ARMED: begin
                if (!fight) begin
                    fsm_d  = ST_IDLE;
                    pend_d = '0;
                    ifc_d  = '0;
                end else if (eof) begin
                    pend_d = '0;
                    if (|eval_bits) begin
                        col_d = eval_bits;
                        hit_d = 1'b1;
                        hp_d  = hp_dmg;
                        if (hp_dmg == '0) begin
                            fsm_d = ST_DEAD;
                        end else begin
                            fsm_d = ST_INVULN;
                            ifc_d = IFR;
                        end
                    end
                end else begin
                    pend_d = pend_p1 | ov;
                end
            end
            ST_INVULN: begin
                pend_d = '0;
                if (!fight) begin
                    fsm_d = ST_IDLE;
                    ifc_d = '0;
                end else if (eof) begin
                    ifc_d = ifc_p1 - 8'd1;
                    if (ifc_p1 == 8'd1) fsm_d = ST_ARMED;
                end
            end
            ST_DEAD: begin
                pend_d = '0;
                hp_d   = '0;
            end
            default: begin
                fsm_d = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        collision    = col_p1;
        hit          = hit_p1;
        hp           = hp_p1;
        invincible   = (fsm_p1 == ST_INVULN);
        gameOver     = (fsm_p1 == ST_DEAD);
        heartVisible = 1'b1;
        if (fsm_p1 == ST_INVULN) heartVisible = ifc_p1[2];
    end

endmodule

// File: tb/tb_heart_hit_manager.sv
// Bench for heart_hit_manager on a shrunken 16x8 raster: frame-level model checked
// every cycle, plus literal checkpoints from the directed scenarios.
module tb_heart_hit_manager;

    localparam int         NB  = 4;
    localparam int         HL  = 15;
    localparam int         VL  = 7;
    localparam int         HPI = 20;
    localparam int         DMG = 4;
    localparam int         IFR = 30;
    localparam logic [3:0] FS  = 4'd1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset;
    logic [3:0]    state;
    logic [9:0]    x, y;
    logic          heartSpriteOn;
    logic [NB-1:0] bulletSpriteOn;

    logic [NB-1:0] collision, s_collision;
    logic [7:0]    hp, s_hp;
    logic          hit, invincible, heartVisible, gameOver;
    logic          s_hit, s_invincible, s_heartVisible, s_gameOver;

    heart_hit_manager #(
        .NUM_BULLETS(NB), .HP_INIT(HPI), .DAMAGE(DMG), .IFRAMES(IFR),
        .H_LAST(HL), .V_LAST(VL), .FIGHT_STATE(FS)
    ) u_dut (
        .clk(clk), .reset(reset), .state(state), .x(x), .y(y),
        .heartSpriteOn(heartSpriteOn), .bulletSpriteOn(bulletSpriteOn),
        .collision(collision), .hp(hp), .hit(hit), .invincible(invincible),
        .heartVisible(heartVisible), .gameOver(gameOver)
    );

    // Second instance starting below DAMAGE, to exercise the saturating subtract.
    heart_hit_manager #(
        .NUM_BULLETS(NB), .HP_INIT(3), .DAMAGE(DMG), .IFRAMES(IFR),
        .H_LAST(HL), .V_LAST(VL), .FIGHT_STATE(FS)
    ) u_dut_sat (
        .clk(clk), .reset(reset), .state(state), .x(x), .y(y),
        .heartSpriteOn(heartSpriteOn), .bulletSpriteOn(bulletSpriteOn),
        .collision(s_collision), .hp(s_hp), .hit(s_hit), .invincible(s_invincible),
        .heartVisible(s_heartVisible), .gameOver(s_gameOver)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Frame-level model: HP, remaining invincibility frames, collected hit mask.
    int          m_hp;
    int          m_inv;
    bit          m_dead;
    bit          m_active;
    logic [3:0]  m_pend;
    logic [3:0]  e_col;
    bit          e_hit;
    bit          chk_en = 1'b0;

    task automatic model_step();
        logic [3:0] ovl;
        logic [3:0] ev;
        bit         at_eof;
        e_col = 4'b0;
        e_hit = 1'b0;
        if (reset) begin
            m_hp = HPI; m_inv = 0; m_dead = 1'b0; m_active = 1'b0; m_pend = 4'b0;
        end else begin
            at_eof = (int'(x) == HL) && (int'(y) == VL);
            ovl    = heartSpriteOn ? bulletSpriteOn : 4'b0;
            if (m_dead) begin
                m_pend = 4'b0;
            end else if (state != FS) begin
                m_active = 1'b0; m_inv = 0; m_pend = 4'b0;
            end else if (!m_active) begin
                m_active = 1'b1;
            end else if (m_inv > 0) begin
                m_pend = 4'b0;
                if (at_eof) m_inv = m_inv - 1;
            end else if (at_eof) begin
                ev     = m_pend | ovl;
                m_pend = 4'b0;
                if (ev != 4'b0) begin
                    e_col = ev;
                    e_hit = 1'b1;
                    m_hp  = (m_hp > DMG) ? m_hp - DMG : 0;
                    if (m_hp == 0) m_dead = 1'b1;
                    else           m_inv  = IFR;
                end
            end else begin
                m_pend = m_pend | ovl;
            end
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check("collision", 32'(collision), 32'(e_col));
            check("hit", 32'(hit), 32'(e_hit));
            check("hp", 32'(hp), 32'(m_hp));
            check("invincible", 32'(invincible), 32'(m_inv > 0));
            check("heartVisible", 32'(heartVisible), (m_inv > 0) ? 32'((m_inv >> 2) & 1) : 32'd1);
            check("gameOver", 32'(gameOver), 32'(m_dead));
        end
        model_step();
    end

    task automatic pix(input logic [9:0] px, input logic [9:0] py, input bit hon,
                       input logic [3:0] bon, input logic [3:0] st, input bit rst);
        x = px; y = py; heartSpriteOn = hon; bulletSpriteOn = bon; state = st; reset = rst;
        @(posedge clk);
        #1;
    endtask

    // Heart is a 3x3 block at (4..6, 2..4), or only the last pixel when last_only.
    // Every bullet also sits at column 12, away from the heart.
    task automatic frame(input logic [3:0] mask, input bit last_only,
                         input logic [3:0] st_eof, input int npix);
        int         cnt;
        bit         in_rect;
        bit         is_eof;
        logic [3:0] bon;
        cnt = 0;
        for (int yy = 0; yy <= VL; yy++) begin
            for (int xx = 0; xx <= HL; xx++) begin
                if (cnt < npix) begin
                    is_eof  = (xx == HL) && (yy == VL);
                    in_rect = last_only ? is_eof : (xx >= 4 && xx <= 6 && yy >= 2 && yy <= 4);
                    bon     = (in_rect ? mask : 4'b0) | ((xx == 12) ? 4'b1111 : 4'b0);
                    pix(10'(xx), 10'(yy), in_rect, bon, is_eof ? st_eof : FS, 1'b0);
                    cnt++;
                end
            end
        end
    endtask

    localparam int FULL = (HL + 1) * (VL + 1);

    initial begin
        reset = 1'b1; state = 4'd0; x = '0; y = '0;
        heartSpriteOn = 1'b0; bulletSpriteOn = '0;
        repeat (3) @(posedge clk);
        #1;
        chk_en = 1'b1;
        check("rst_hp", 32'(hp), 32'd20);
        check("rst_heartVisible", 32'(heartVisible), 32'd1);
        check("rst_collision", 32'(collision), 32'd0);
        check("rst_gameOver", 32'(gameOver), 32'd0);
        check("rst_sat_hp", 32'(s_hp), 32'd3);

        frame(4'b0001, 1'b0, FS, FULL);
        check("a_collision", 32'(collision), 32'b0001);
        check("a_hit", 32'(hit), 32'd1);
        check("a_hp", 32'(hp), 32'd16);
        check("a_invincible", 32'(invincible), 32'd1);
        check("sat_hp", 32'(s_hp), 32'd0);
        check("sat_gameOver", 32'(s_gameOver), 32'd1);
        check("sat_collision", 32'(s_collision), 32'b0001);

        for (int k = 1; k <= IFR; k++) begin
            frame(4'b1111, 1'b0, FS, FULL);
            if (k == 1) check("inv_no_pulse", 32'(collision), 32'd0);
            if (k == 1) check("sat_dead_no_pulse", 32'(s_collision), 32'd0);
            if (k == 3) check("blink_off", 32'(heartVisible), 32'd0);
            if (k == 7) check("blink_on", 32'(heartVisible), 32'd1);
            if (k == 29) check("inv_29", 32'(invincible), 32'd1);
            if (k == 30) check("inv_30_armed", 32'(invincible), 32'd0);
            if (k == 30) check("inv_hp_held", 32'(hp), 32'd16);
        end

        frame(4'b1010, 1'b0, FS, FULL);
        check("b_collision", 32'(collision), 32'b1010);
        check("b_hp", 32'(hp), 32'd12);
        for (int k = 0; k < IFR; k++) frame(4'b0000, 1'b0, FS, FULL);

        frame(4'b0001, 1'b1, FS, FULL);
        check("last_px_collision", 32'(collision), 32'b0001);
        check("last_px_hp", 32'(hp), 32'd8);
        for (int k = 0; k < IFR; k++) frame(4'b0000, 1'b0, FS, FULL);

        frame(4'b0100, 1'b0, 4'd2, FULL);
        check("eof_state_hit", 32'(hit), 32'd0);
        check("eof_state_hp", 32'(hp), 32'd8);
        check("eof_state_inv", 32'(invincible), 32'd0);
        frame(4'b0000, 1'b0, FS, FULL);
        check("idle_pend_cleared", 32'(hit), 32'd0);

        frame(4'b0001, 1'b0, FS, FULL);
        check("f_hp", 32'(hp), 32'd4);
        for (int k = 0; k < IFR; k++) frame(4'b0000, 1'b0, FS, FULL);
        frame(4'b1111, 1'b0, FS, FULL);
        check("dead_collision", 32'(collision), 32'b1111);
        check("dead_hp", 32'(hp), 32'd0);
        check("dead_gameOver", 32'(gameOver), 32'd1);
        frame(4'b1111, 1'b0, FS, FULL);
        check("dead_no_pulse", 32'(hit), 32'd0);
        check("dead_sticky", 32'(gameOver), 32'd1);

        pix(10'd0, 10'd0, 1'b0, 4'b0, FS, 1'b1);
        check("rst2_hp", 32'(hp), 32'd20);
        check("rst2_gameOver", 32'(gameOver), 32'd0);
        frame(4'b0001, 1'b0, FS, FULL);
        check("g_hp", 32'(hp), 32'd16);
        frame(4'b1111, 1'b0, FS, 60);
        pix(10'd12, 10'd3, 1'b1, 4'b1111, FS, 1'b1);
        check("rst_inv_hp", 32'(hp), 32'd20);
        check("rst_inv_collision", 32'(collision), 32'd0);
        check("rst_inv_invincible", 32'(invincible), 32'd0);
        check("rst_inv_heartVisible", 32'(heartVisible), 32'd1);
        check("rst_inv_sat_hp", 32'(s_hp), 32'd3);

        frame(4'b0001, 1'b0, FS, 60);
        pix(10'd0, 10'd4, 1'b0, 4'b0, FS, 1'b1);
        frame(4'b0000, 1'b0, FS, FULL);
        check("rst_armed_discard", 32'(hit), 32'd0);
        check("rst_armed_hp", 32'(hp), 32'd20);

        repeat (3) pix(10'd0, 10'd0, 1'b0, 4'b0, FS, 1'b0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/heart_hit_manager.md
# heart_hit_manager

Per-pixel collision and damage stage that sits directly downstream of the bullet sprite generators and the heart (player) sprite. It watches the per-pixel sprite-on flags from every bullet and from the heart during the fight state. It latches overlaps across a frame and, at end of frame, applies damage, starts invincibility frames and returns a one-cycle `collision` pulse to each bullet that hit. The bullet sprite consumes that pulse to retire itself. The block also drives the HP value, the game-over flag and the heart blink enable.

## Interface
Parameters:
- `NUM_BULLETS`, 4: number of bullet sprite inputs.
- `HP_INIT`, 20: HP loaded at reset, 8-bit range.
- `DAMAGE`, 4: HP removed per damaging frame.
- `IFRAMES`, 30: invincibility length in frames, 1..255.
- `H_LAST`, 639; `V_LAST`, 479: pixel coordinates that mark end of frame.
- `FIGHT_STATE`, 1: value of `state` in which hits count.

Ports:
- `clk`, in, 1: pixel clock. One clock; reset is synchronous and active-high.
- `reset`, in, 1: synchronous, active-high.
- `state`, in, 4: game state.
- `x`, `y`, in, 10 each: current pixel coordinates.
- `heartSpriteOn`, in, 1: heart covers the current pixel.
- `bulletSpriteOn`, in, `NUM_BULLETS`: bit i means bullet i covers the current pixel.
- `collision`, out, `NUM_BULLETS`: one-cycle pulse per bullet that caused damage.
- `hp`, out, 8: current HP.
- `hit`, out, 1: one-cycle pulse when damage is applied.
- `invincible`, out, 1: high while invincibility frames run.
- `heartVisible`, out, 1: heart draw enable (blink).
- `gameOver`, out, 1: sticky once HP reaches 0.

## Operation
- FSM states:
  - IDLE: `state`≠FIGHT_STATE.
  - ARMED: fight, vulnerable.
  - INVULN: fight, counting down.
  - DEAD: HP is 0.
- Reset: FSM IDLE, `hp`=HP_INIT, pending=0, counters=0. All outputs are 0 except `hp`=HP_INIT and `heartVisible`=1.
- Overlap: `ov[i] = heartSpriteOn & bulletSpriteOn[i]`. In ARMED, `pending[i] <= pending[i] | ov[i]` every cycle.
- End of frame (`eof`) is the cycle with x==H_LAST && y==V_LAST.
  - Evaluation uses `pending | ov` so an overlap on the final pixel still counts.
- At `eof` in ARMED with any evaluated bit set:
  - `collision <= evaluated bits`.
  - `hit <= 1`.
  - `hp <= (hp > DAMAGE) ? hp-DAMAGE : 0` (saturating, no wrap).
  - If the new hp is 0: go to DEAD and set `gameOver`. Otherwise go to INVULN with `ifc <= IFRAMES`.
- Every `eof` clears pending.
- INVULN:
  - Overlaps are ignored and bullets pass through; pending stays 0.
  - `ifc` decrements at each `eof`. When a decrement reaches 0, go to ARMED.
  - `heartVisible` = bit 2 of `ifc`; it is 1 outside INVULN.
- IDLE:
  - Entered from ARMED or INVULN whenever `state`≠FIGHT_STATE.
  - Clears pending and `ifc`. `hp` is held.
  - Returns to ARMED when `state`==FIGHT_STATE.
- DEAD: absorbing until `reset`. No pulses; `hp`=0, `gameOver`=1.
- Simultaneous hits on one frame from several bullets: a single DAMAGE is applied and all hitting bullets pulse together.

## Timing
- `collision` and `hit` are registered. They are high for exactly the one cycle after the `eof` cycle, and 0 otherwise.
- `hp`, `invincible`, `gameOver` and `heartVisible` update on that same cycle.
- Latency from the first overlap pixel to the `collision` pulse is at most one frame plus one cycle.
- `reset` wins over every event in the same cycle. A reset mid-frame discards pending.
- A `state` change on the `eof` cycle takes priority: go to IDLE with no damage applied.
- `invincible` = FSM==INVULN, registered.

## Structure
- Shared package holds the FSM state encoding (IDLE/ARMED/INVULN/DEAD, 2 bits) and the constants H_LAST, V_LAST and FIGHT_STATE, which the bullet sprites also use.
- One natural sub-module, `frame_tick`: decodes `eof` from x/y as a registered-free comparator with enable. It is reusable by the sprite movers.
- Datapath: pending vector, saturating subtractor, 8-bit `ifc` down-counter.

## Test plan
- Heart and bullet 0 overlap for 9 pixels in one ARMED frame, HP=20, DAMAGE=4 → one cycle after `eof`: `collision`=4'b0001, `hit`=1, `hp`=16, `invincible`=1.
- In INVULN with IFRAMES=30, overlaps on every frame → no `collision` pulses and `hp` stays 16. After exactly 30 `eof`s, FSM is ARMED. `heartVisible` toggles every 4 frames.
- Bullets 1 and 3 overlap the heart in the same frame → `collision`=4'b1010, a single `hp` decrement of 4.
- HP=3, hit with DAMAGE=4 → `hp`=0, `gameOver`=1, FSM DAMAGE-free DEAD. Later overlaps produce no pulses until `reset`.
- Overlap only at pixel (639,479) → damage applied at that `eof`. `state` set to 2 on the `eof` cycle with pending set → no damage, FSM IDLE, `hp` unchanged.
- `reset` asserted mid-INVULN with pending set → next cycle `hp`=20, all pulses 0, FSM IDLE, `heartVisible`=1.
